phys_free_list: RTL and testbench
=================================

Name: phys_free_list

Overview:
- Circular free list of physical register tags for the out-of-order core's rename stage.
- Supplies a fresh destination tag (rd_phys) to rename/ROB allocation.
- Reclaims the tag (old_phys) released by the ROB on commit.
- Restores its read pointer on a branch-mispredict flush using per-ROB-slot checkpoints, so tags taken by squashed instructions return to the list.

Parameters:
- NUM_PHYS, 64, total physical registers.
- NUM_ARCH, 32, architectural registers; p0..p31 are mapped at reset.
- ROB_SIZE, 16, ROB entries; sizes the checkpoint array.
- DEPTH, NUM_PHYS-NUM_ARCH (32), free-list capacity.
- PHYS_BITS, $clog2(NUM_PHYS), tag width.
- ROB_BITS, $clog2(ROB_SIZE), ROB index width.
- PTR_BITS, $clog2(DEPTH)+1, pointer width including the wrap bit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  rename requests one tag this cycle.
- alloc_rob_idx  in  ROB_BITS  ROB slot receiving the allocation (ROB alloc_idx).
- alloc_gnt  out  1  alloc_req && alloc_valid; a pop occurs this cycle.
- alloc_valid  out  1  list non-empty.
- alloc_phys  out  PHYS_BITS  tag at the read pointer (show-ahead).
- free_en  in  1  ROB commit releases a tag (ROB commit_valid).
- free_phys  in  PHYS_BITS  tag to return (ROB free_phys).
- flush  in  1  mispredict recovery.
- flush_idx  in  ROB_BITS  oldest squashed ROB slot.
- free_count  out  PTR_BITS  wr_ptr - rd_ptr.
- overflow_err  out  1  sticky: push attempted while full.

Behaviour:
- Storage: fifo[DEPTH] of PHYS_BITS; rd_ptr and wr_ptr are PTR_BITS with a wrap bit; address = ptr[PTR_BITS-2:0].
- Checkpoint array: ckpt[ROB_SIZE] of PTR_BITS.
- Reset (async, rst_n=0):
  - fifo[i] = NUM_ARCH+i; rd_ptr = 0; wr_ptr = DEPTH (wrap bit 1, i.e. full).
  - ckpt cleared; overflow_err = 0.
  - Outputs: alloc_valid=1, alloc_phys=32, free_count=32, alloc_gnt=0 when alloc_req=0.
- Reset mid-operation: all state reinitialised immediately; no drain.
- Empty when rd_ptr == wr_ptr. Full when addresses are equal and wrap bits differ.
- Allocate (flush=0):
  - If alloc_req and not empty: alloc_gnt=1 combinationally; alloc_phys valid in the same cycle.
  - Next edge: ckpt[alloc_rob_idx] <= rd_ptr (value before the pop); rd_ptr <= rd_ptr+1.
  - Zero-latency show-ahead: the next tag appears the cycle after the pop.
- Empty: alloc_gnt=0 and no pop. Rename must stall.
- No free-to-alloc bypass: a tag freed in cycle N is allocatable in cycle N+1 at the earliest.
- Free:
  - free_en with free_phys != 0 and not full: fifo[wr_ptr] <= free_phys; wr_ptr++.
  - free_phys == 0 is ignored; p0 is permanently bound to x0.
- Free while full: write dropped, overflow_err <= 1 (sticky until reset); simulation assertion fires.
- Simultaneous alloc and free (non-empty, non-full): both happen; free_count unchanged.
- Flush:
  - rd_ptr <= ckpt[flush_idx]. alloc_req is ignored (alloc_gnt forced 0).
  - free_en in the same cycle is still honoured (wr_ptr advances).
  - Correctness: in-flight tags ≤ DEPTH, so squashed entries between ckpt and rd_ptr are never overwritten.
- Pointer arithmetic is modulo 2^PTR_BITS; wrap-around is natural.
- free_count = wr_ptr - rd_ptr, PTR_BITS wide, range 0..DEPTH.
- Caller contract: flush_idx must name a slot allocated since the last reset.

Decomposition:
- Shared package core_pkg holds:
  - NUM_PHYS, NUM_ARCH, ROB_SIZE.
  - typedefs phys_tag_t (logic [PHYS_BITS-1:0]) and rob_idx_t (logic [ROB_BITS-1:0]), reused by rename, the ROB and this block.
- Single module. The checkpoint array is a plain register file and is not split out.

Test Plan:
- Reset then 3 back-to-back grants at rob idx 0,1,2 -> alloc_phys 32,33,34; free_count 29; alloc_phys shows 35.
- 32 consecutive grants -> alloc_valid=0, free_count=0; a 33rd alloc_req gets alloc_gnt=0 and rd_ptr is unchanged.
- From empty, free_en with free_phys=10 and alloc_req in the same cycle -> no grant that cycle; next cycle alloc_gnt=1, alloc_phys=10; after wrap, the order of freed tags is preserved.
- Grants at rob idx 5,6,7 return 32,33,34; flush with flush_idx=6 -> next alloc_phys=33, free_count=31; a concurrent free of 12 -> free_count=32.
- free_en with free_phys=0 -> no change. free_en with free_phys=20 while full -> overflow_err=1 and stays 1; fifo contents unchanged.
- rst_n asserted mid-burst (asynchronously, between edges) -> alloc_phys=32, free_count=32, overflow_err=0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: sizing constants and tag/index types shared by rename, the ROB
// and the physical-register free list.
package core_pkg;

  localparam int NUM_PHYS  = 64;                    // total physical registers
  localparam int NUM_ARCH  = 32;                    // p0..p31 mapped at reset
  localparam int ROB_SIZE  = 16;                    // ROB entries
  localparam int DEPTH     = NUM_PHYS - NUM_ARCH;   // free-list capacity
  localparam int PHYS_BITS = $clog2(NUM_PHYS);
  localparam int ROB_BITS  = $clog2(ROB_SIZE);
  localparam int PTR_BITS  = $clog2(DEPTH) + 1;     // extra MSB is the wrap bit

  typedef logic [PHYS_BITS-1:0] phys_tag_t;
  typedef logic [ROB_BITS-1:0]  rob_idx_t;
  typedef logic [PTR_BITS-1:0]  fl_ptr_t;

  // Storage address of a free-list pointer (drops the wrap bit).
  function automatic logic [PTR_BITS-2:0] ptr_addr(input fl_ptr_t ptr);
    return ptr[PTR_BITS-2:0];
  endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// phys_free_list_if: rename/ROB <-> free-list connection.
//   master (rename + ROB side): drives alloc_req, alloc_rob_idx, free_en,
//     free_phys, flush, flush_idx; observes alloc_gnt, alloc_valid,
//     alloc_phys, free_count, overflow_err.
//   slave (free list): the mirror image.
interface phys_free_list_if;
  import core_pkg::*;

  logic      alloc_req;
  rob_idx_t  alloc_rob_idx;
  logic      alloc_gnt;
  logic      alloc_valid;
  phys_tag_t alloc_phys;
  logic      free_en;
  phys_tag_t free_phys;
  logic      flush;
  rob_idx_t  flush_idx;
  fl_ptr_t   free_count;
  logic      overflow_err;

  modport master (
    output alloc_req, alloc_rob_idx, free_en, free_phys, flush, flush_idx,
    input  alloc_gnt, alloc_valid, alloc_phys, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, alloc_rob_idx, free_en, free_phys, flush, flush_idx,
    output alloc_gnt, alloc_valid, alloc_phys, free_count, overflow_err
  );

endinterface

// File: rtl/phys_free_list_chk.sv
// phys_free_list_chk: simulation-only observer. Reports a tag release that
// arrived while the free list was already full (the tag is dropped).
//   clk, rst_n   : clock / async active-low reset
//   drop_i       : a non-zero free was attempted while full this cycle
//   free_phys_i  : tag that was dropped
module phys_free_list_chk
  import core_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  input logic      drop_i,
  input phys_tag_t free_phys_i
);

  // Flag every dropped release at the clock edge that would have stored it.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!drop_i)
        else $warning("free list full, released tag %0d dropped", free_phys_i);
    end
  end

endmodule

// File: rtl/phys_free_list.sv
// phys_free_list: circular free list of physical register tags.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (list refilled with p32..p63)
//   bus    : slave side of phys_free_list_if
//     alloc_*  show-ahead tag supply to rename, one pop per granted request
//     free_*   tag release from ROB commit (p0 is never returned)
//     flush*   read pointer restored from the checkpoint of the oldest
//              squashed ROB slot, returning its tags to the list
//     free_count / overflow_err  occupancy and sticky push-while-full flag
module phys_free_list
  import core_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  phys_free_list_if.slave bus
);

  phys_tag_t fifo_q [DEPTH];
  fl_ptr_t   ckpt_q [ROB_SIZE];

  fl_ptr_t rd_q, rd_d;
  fl_ptr_t wr_q, wr_d;
  logic    ovf_q, ovf_d;

  logic empty_s;
  logic full_s;
  logic gnt_s;
  logic rel_s;    // a real (non-p0) tag is being released
  logic push_s;
  logic drop_s;

  assign empty_s = (rd_q == wr_q);
  assign full_s  = (ptr_addr(rd_q) == ptr_addr(wr_q)) &&
                   (rd_q[PTR_BITS-1] != wr_q[PTR_BITS-1]);

  // Flush owns the read pointer, so it squashes any same-cycle request.
  assign gnt_s  = bus.alloc_req && !empty_s && !bus.flush;
  assign rel_s  = bus.free_en && (bus.free_phys != phys_tag_t'(0));
  assign push_s = rel_s && !full_s;
  assign drop_s = rel_s && full_s;

  // Next-state for the pointers and the sticky overflow flag.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    ovf_d = ovf_q;
    if (bus.flush) begin
      rd_d = ckpt_q[bus.flush_idx];
    end else if (gnt_s) begin
      rd_d = rd_q + fl_ptr_t'(1);
    end else begin
      rd_d = rd_q;
    end
    if (push_s) begin
      wr_d = wr_q + fl_ptr_t'(1);
    end else begin
      wr_d = wr_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pointer and overflow registers; reset leaves the list full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= fl_ptr_t'(0);
      wr_q  <= fl_ptr_t'(DEPTH);
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      ovf_q <= ovf_d;
    end
  end

  // Tag storage: preloaded with the unmapped tags, written on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= phys_tag_t'(NUM_ARCH + i);
      end
    end else if (push_s) begin
      fifo_q[ptr_addr(wr_q)] <= bus.free_phys;
    end
  end

  // Checkpoints: read pointer before each slot's pop, used to rewind on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ckpt_q[i] <= fl_ptr_t'(0);
      end
    end else if (gnt_s) begin
      ckpt_q[bus.alloc_rob_idx] <= rd_q;
    end
  end

  assign bus.alloc_gnt    = gnt_s;
  assign bus.alloc_valid  = !empty_s;
  assign bus.alloc_phys   = fifo_q[ptr_addr(rd_q)];
  assign bus.free_count   = wr_q - rd_q;
  assign bus.overflow_err = ovf_q;

  phys_free_list_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .drop_i      (drop_s),
    .free_phys_i (bus.free_phys)
  );

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list. The reference model is an unbounded log of every
// tag ever placed on the list (hist) plus an integer read count: the tag
// offered is hist[rd_cnt], occupancy is hist.size()-rd_cnt, and a flush
// rewinds rd_cnt to the count recorded when the flushed slot allocated.
module tb_phys_free_list;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phys_free_list_if bus ();

  phys_free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int hist[$];
  int rd_cnt;
  int ckpt_m [ROB_SIZE];
  bit ovf_m;

  int rob_idx_q[$];
  int rob_tag_q[$];
  int next_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(NUM_ARCH + i);
    rd_cnt = 0;
    ovf_m  = 1'b0;
    for (int i = 0; i < ROB_SIZE; i++) ckpt_m[i] = 0;
    rob_idx_q.delete();
    rob_tag_q.delete();
    next_idx = 0;
  endtask

  task automatic drive(input bit req, input int ridx, input bit fen, input int fp,
                       input bit fl, input int fidx);
    bus.alloc_req     = req;
    bus.alloc_rob_idx = rob_idx_t'(ridx);
    bus.free_en       = fen;
    bus.free_phys     = phys_tag_t'(fp);
    bus.flush         = fl;
    bus.flush_idx     = rob_idx_t'(fidx);
  endtask

  // One cycle: drive after the falling edge, check outputs, clock, update model.
  task automatic step(input bit req, input int ridx, input bit fen, input int fp,
                      input bit fl, input int fidx);
    int cnt;
    bit exp_gnt;
    drive(req, ridx, fen, fp, fl, fidx);
    #1;
    cnt     = hist.size() - rd_cnt;
    exp_gnt = req && !fl && (cnt > 0);
    chk("alloc_valid", bus.alloc_valid, cnt > 0);
    chk("alloc_gnt", bus.alloc_gnt, exp_gnt);
    chk("free_count", bus.free_count, cnt);
    chk("overflow_err", bus.overflow_err, ovf_m);
    if (cnt > 0) chk("alloc_phys", bus.alloc_phys, hist[rd_cnt]);
    @(posedge clk);
    if (exp_gnt) begin
      ckpt_m[ridx] = rd_cnt;
      rd_cnt++;
    end
    if (fl) rd_cnt = ckpt_m[fidx];
    if (fen && fp != 0) begin
      if (cnt < DEPTH) hist.push_back(fp);
      else ovf_m = 1'b1;
    end
    @(negedge clk);
  endtask

  // Reset asserted between edges while a request is active; effect is immediate.
  task automatic async_reset();
    drive(1'b1, 0, 1'b1, 9, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_alloc_phys", bus.alloc_phys, 32);
    chk("rst_free_count", bus.free_count, 32);
    chk("rst_overflow", bus.overflow_err, 0);
    chk("rst_alloc_valid", bus.alloc_valid, 1);
    model_reset();
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, k, kk, fidx, fp, tag;
    bit req, fen, fl, commit, gnt;

    model_reset();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    chk("init_free_count", bus.free_count, 32);
    chk("init_alloc_phys", bus.alloc_phys, 32);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0);

    // Three back-to-back grants.
    step(1'b1, 0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 2, 1'b0, 0, 1'b0, 0);
    chk("after3_count", bus.free_count, 29);
    chk("after3_phys", bus.alloc_phys, 35);

    // Drain to empty; one more request must not pop.
    for (int i = 3; i < DEPTH; i++) step(1'b1, i % ROB_SIZE, 1'b0, 0, 1'b0, 0);
    chk("empty_valid", bus.alloc_valid, 0);
    chk("empty_count", bus.free_count, 0);
    step(1'b1, 0, 1'b0, 0, 1'b0, 0);
    chk("empty_count_hold", bus.free_count, 0);

    // Free into an empty list with a same-cycle request: no bypass.
    step(1'b1, 1, 1'b1, 10, 1'b0, 0);
    chk("freed_phys", bus.alloc_phys, 10);
    chk("freed_valid", bus.alloc_valid, 1);
    step(1'b1, 2, 1'b0, 0, 1'b0, 0);
    // Ordering across the storage wrap.
    step(1'b0, 0, 1'b1, 40, 1'b0, 0);
    step(1'b0, 0, 1'b1, 41, 1'b0, 0);
    step(1'b0, 0, 1'b1, 42, 1'b0, 0);
    chk("wrap_first", bus.alloc_phys, 40);
    for (int i = 0; i < 4; i++) step(1'b1, 3 + i, 1'b0, 0, 1'b0, 0);

    async_reset();

    // Flush rewinds to the checkpoint of slot 6.
    step(1'b1, 5, 1'b0, 0, 1'b0, 0);
    step(1'b1, 6, 1'b0, 0, 1'b0, 0);
    step(1'b1, 7, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0, 1'b1, 6);
    chk("flush_phys", bus.alloc_phys, 33);
    chk("flush_count", bus.free_count, 31);
    step(1'b1, 6, 1'b0, 0, 1'b0, 0);
    step(1'b1, 7, 1'b0, 0, 1'b0, 0);
    step(1'b1, 8, 1'b1, 12, 1'b1, 6);   // request ignored, free honoured
    chk("flush_free_count", bus.free_count, 32);
    chk("flush_free_phys", bus.alloc_phys, 33);

    // p0 release ignored; release while full is dropped and sticky.
    step(1'b0, 0, 1'b1, 0, 1'b0, 0);
    chk("p0_count", bus.free_count, 32);
    step(1'b0, 0, 1'b1, 20, 1'b0, 0);
    chk("ovf_set", bus.overflow_err, 1);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0);
    chk("ovf_sticky", bus.overflow_err, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, i % ROB_SIZE, 1'b0, 0, 1'b0, 0);
    chk("drain_empty", bus.alloc_valid, 0);

    // Randomized traffic with an ROB-like model of in-flight tags.
    async_reset();
    for (int n = 0; n < 500; n++) begin
      cnt    = hist.size() - rd_cnt;
      commit = (rob_idx_q.size() > 0) && ($urandom_range(0, 2) == 0);
      fl     = (rob_idx_q.size() > (commit ? 1 : 0)) && ($urandom_range(0, 11) == 0);
      req    = ($urandom_range(0, 3) != 0) && (rob_idx_q.size() < ROB_SIZE);
      k = 0;
      fidx = 0;
      if (fl) begin
        k = $urandom_range(commit ? 1 : 0, rob_idx_q.size() - 1);
        fidx = rob_idx_q[k];
      end
      fen = commit;
      fp  = commit ? rob_tag_q[0] : 0;
      if (!commit && $urandom_range(0, 7) == 0) fen = 1'b1;   // p0 release
      gnt = req && !fl && (cnt > 0);
      tag = gnt ? hist[rd_cnt] : 0;
      step(req, next_idx, fen, fp, fl, fidx);
      if (commit) begin
        void'(rob_idx_q.pop_front());
        void'(rob_tag_q.pop_front());
      end
      if (fl) begin
        kk = k - (commit ? 1 : 0);
        while (rob_idx_q.size() > kk) begin
          void'(rob_idx_q.pop_back());
          void'(rob_tag_q.pop_back());
        end
        next_idx = fidx;
      end
      if (gnt) begin
        rob_idx_q.push_back(next_idx);
        rob_tag_q.push_back(tag);
        next_idx = (next_idx + 1) % ROB_SIZE;
      end
    end

    async_reset();
    step(1'b0, 0, 1'b0, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
